y_muldiv: RTL and testbench
===========================

// Module: y_muldiv
//
// PURPOSE
// Iterative multiply/divide unit beside yEX, fed by the rd1/rd2 outputs of yID.
// Executes MULT/MULTU/DIV/DIVU in a radix-2 shift-add / restoring-divide datapath
// and holds the 2*WIDTH result in HI/LO registers for later move-to-GPR reads.
// Start/busy/done handshake; the control path stalls issue while busy is high.
//
// PARAMETERS
// WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
//
// PORTS
// clk    in   1      rising-edge clock
// rst    in   1      asynchronous reset, active high
// start  in   1      launch request; sampled only when state is IDLE
// op     in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV (bit0 = signed)
// a      in   WIDTH  multiplicand / dividend (rd1)
// b      in   WIDTH  multiplier / divisor (rd2)
// busy   out  1      operation in progress; issue must stall
// done   out  1      one-cycle pulse; hi/lo/div0 valid this cycle
// div0   out  1      divide-by-zero flag for the completed operation
// hi     out  WIDTH  mult: upper product; div: remainder
// lo     out  WIDTH  mult: lower product; div: quotient
//
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; busy, done, div0 = 0; hi, lo = 0; op aborted.
// - States: IDLE -> RUN -> FIN -> IDLE.
//   IDLE: start=1 latches a, b, op; converts signed operands to magnitudes; -> RUN.
//   RUN: one iteration per cycle, internal counter WIDTH-1 down to 0; at 0 -> FIN.
//   FIN: sign fix-up, write hi/lo/div0, done=1 next cycle; -> IDLE.
// - Latency fixed: start sampled at edge E0; busy=1 from E0 through E0+WIDTH+1;
//   done=1 and busy=0 during the cycle after edge E0+WIDTH+2. Independent of data.
// - Back-to-back: start asserted in the done cycle is accepted (state is IDLE).
// - start while busy: ignored, no queuing; a, b, op changes while busy are ignored.
// - hi/lo/div0 change only at completion; held otherwise.
// - Multiply: {hi,lo} = a*b; signed result = two's complement of 2*WIDTH product.
// - Divide: quotient truncates toward zero; remainder takes sign of dividend.
// - Signed overflow (a = most-negative, b = -1): lo = a, hi = 0, div0 = 0.
// - b = 0 on DIV/DIVU: full latency still taken; div0=1, hi=a, lo=all ones.
// - div0 = 0 for every multiply and every non-zero divide.
//
// CONFIGURATION
// - MULDIV_SIGNED_EN defined: op[0] selects signed operation as above
//   (operand negation in IDLE, result negation in FIN).
// - Undefined: op[0] ignored; MULT behaves as MULTU, DIV as DIVU.
//   Negation logic omitted. Latency and div0 behaviour unchanged.
//
// TESTING (WIDTH=32, MULDIV_SIGNED_EN defined unless noted)
// - MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 edges after start;
//   hi=0xFFFFFFFE lo=0x00000001.
// - MULT a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; undefined macro: hi=0x4 lo=0xFFFFFFF1.
// - DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
// - DIVU a=100 b=0 -> div0=1, hi=0x64, lo=0xFFFFFFFF, same 34-edge latency.
// - start pulsed again at cycle 5 with new operands -> ignored, first result intact;
//   start in done cycle -> second op accepted, completes 34 edges later.
// - rst asserted mid-RUN (cycle 10) -> busy/done/div0/hi/lo = 0 immediately;
//   fresh MULTU 6*7 afterwards -> lo=0x2A hi=0.

Source files
------------

// File: rtl/y_muldiv.sv
// y_muldiv: iterative multiply/divide unit sitting beside yEX.
//
// Runs MULT/MULTU/DIV/DIVU one bit per cycle. Multiply uses radix-2 shift-add and
// divide uses restoring division. The 2*WIDTH result is held in HI/LO until the
// next operation completes. Latency is fixed at WIDTH+2 edges from the start edge
// to the done cycle and does not depend on the data.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous reset, active high
//   start  launch request, sampled only in IDLE
//   op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV (bit0 = signed)
//   a, b   multiplicand/dividend, multiplier/divisor
//   busy   operation in progress (issue stalls)
//   done   one-cycle pulse, hi/lo/div0 valid in this cycle
//   div0   divide-by-zero flag of the last completed operation
//   hi     mult: upper product, div: remainder
//   lo     mult: lower product, div: quotient
//
// Configuration macro: MULDIV_SIGNED_EN
//   defined   - op[0] selects signed operation (operand and result negation)
//   undefined - op[0] is ignored and every operation is unsigned

module y_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic             fin_last_q;  // second FIN cycle: commit to hi/lo
  logic             is_div_q;
  logic             zero_q;      // divisor was zero
  logic [WIDTH-1:0] acc_q;       // partial product high half / partial remainder
  logic [WIDTH-1:0] lo_q;        // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] bm_q;        // multiplicand / divisor magnitude

  logic             done_q, div0_q;
  logic [WIDTH-1:0] hi_q, lo_out_q;

  // Operand magnitudes and sign flags.
  logic [WIDTH-1:0] a_mag, b_mag;
`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_res_q;  // product or quotient negative
  logic neg_rem_q;  // remainder negative (follows dividend)

  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_mag = a;
  assign b_mag = b;
`endif

  // One datapath iteration.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] acc_step, lo_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, bm_q} : '0);
    rem_sh   = {acc_q, lo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, bm_q};
    if (is_div_q) begin
      // Bit WIDTH of the difference is the borrow: divisor did not fit.
      if (rem_diff[WIDTH]) begin
        acc_step = rem_sh[WIDTH-1:0];
        lo_step  = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = rem_diff[WIDTH-1:0];
        lo_step  = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step = mul_sum[WIDTH:1];
      lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the raw magnitude result, registered in the first FIN cycle.
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    res_hi = acc_q;
    res_lo = lo_q;
`ifdef MULDIV_SIGNED_EN
    if (is_div_q) begin
      if (neg_rem_q) res_hi = -acc_q;
      if (neg_res_q) res_lo = -lo_q;
    end else if (neg_res_q) begin
      {res_hi, res_lo} = -{acc_q, lo_q};
    end
`endif
    // With a zero divisor the remainder path shifts the whole dividend through
    // unchanged, so hi already equals a; only the quotient needs forcing.
    if (is_div_q && zero_q) res_lo = '1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start)       state_d = StRun;
      StRun:   if (cnt_q == '0) state_d = StFin;
      StFin:   if (fin_last_q)  state_d = StIdle;
      default:                  state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (state_q != StIdle);
    done = done_q;
    div0 = div0_q;
    hi   = hi_q;
    lo   = lo_out_q;
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      fin_last_q <= 1'b0;
      is_div_q   <= 1'b0;
      zero_q     <= 1'b0;
      acc_q      <= '0;
      lo_q       <= '0;
      bm_q       <= '0;
      done_q     <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_out_q   <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q      <= CntW'(WIDTH - 1);
            fin_last_q <= 1'b0;
            is_div_q   <= op[1];
            zero_q     <= (b == '0);
            acc_q      <= '0;
            lo_q       <= a_mag;
            bm_q       <= b_mag;
`ifdef MULDIV_SIGNED_EN
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
`endif
          end
        end
        StRun: begin
          acc_q <= acc_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q - 1'b1;
        end
        StFin: begin
          if (!fin_last_q) begin
            acc_q      <= res_hi;
            lo_q       <= res_lo;
            fin_last_q <= 1'b1;
          end else begin
            hi_q     <= acc_q;
            lo_out_q <= lo_q;
            div0_q   <= is_div_q & zero_q;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_y_muldiv.sv
module tb_y_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int lat;
  bit bad_busy, bad_hold;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  y_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start immediately (caller is #1 after an edge, DUT idle), then waits
  // for done with a cycle bound. Operands are scrambled after the start edge;
  // optionally a second start is pulsed 5 cycles in.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit interfere);
    logic [31:0] hi0, lo0;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    hi0 = hi; lo0 = lo;
    lat = 0; bad_busy = 1'b0; bad_hold = 1'b0;
    while (!done && lat < 100) begin
      if (!busy) bad_busy = 1'b1;
      if (hi !== hi0 || lo !== lo0) bad_hold = 1'b1;
      if (interfere && lat == 5) begin
        start = 1'b1; op = DIVU; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                               input logic ediv0);
    check({tag, " latency"}, 64'(lat), 64'd34);
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
    check({tag, " div0"}, 64'(div0), 64'(ediv0));
    check({tag, " busy-clear"}, 64'(busy), 64'd0);
    check({tag, " busy-held"}, 64'(bad_busy), 64'd0);
    check({tag, " result-held"}, 64'(bad_hold), 64'd0);
  endtask

  initial begin
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset div0", 64'(div0), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    expect_result("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    check("done pulse", 64'(done), 64'd0);

`ifdef MULDIV_SIGNED_EN
    run_op(MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    expect_result("mult -3*5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op(MULT, 32'd7, 32'hFFFF_FFFA, 1'b0);
    expect_result("mult 7*-6", 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    expect_result("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    expect_result("div 7/-2", 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_result("div ovf", 32'h0, 32'h8000_0000, 1'b0);
`else
    run_op(MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    expect_result("mult -3*5", 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
    run_op(MULT, 32'd7, 32'hFFFF_FFFA, 1'b0);
    expect_result("mult 7*-6", 32'h0000_0006, 32'hFFFF_FFD6, 1'b0);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    expect_result("div -7/2", 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    expect_result("div 7/-2", 32'h0000_0007, 32'h0, 1'b0);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_result("div ovf", 32'h8000_0000, 32'h0, 1'b0);
`endif

    run_op(DIVU, 32'd100, 32'd7, 1'b0);
    expect_result("divu 100/7", 32'd2, 32'd14, 1'b0);

    // Second start while busy must be ignored.
    run_op(MULTU, 32'd3, 32'd4, 1'b1);
    expect_result("ignore start", 32'd0, 32'd12, 1'b0);

    // Start in the done cycle is accepted.
    run_op(DIVU, 32'd1000, 32'd10, 1'b0);
    expect_result("b2b first", 32'd0, 32'd100, 1'b0);
    run_op(MULTU, 32'h0001_0000, 32'h0003_0000, 1'b0);
    expect_result("b2b second", 32'h0000_0003, 32'h0, 1'b0);

    run_op(DIVU, 32'd100, 32'd0, 1'b0);
    expect_result("divu by 0", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);

    // Asynchronous reset in the middle of RUN.
    op = MULTU; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid-rst busy", 64'(busy), 64'd0);
    check("mid-rst done", 64'(done), 64'd0);
    check("mid-rst div0", 64'(div0), 64'd0);
    check("mid-rst hi", 64'(hi), 64'd0);
    check("mid-rst lo", 64'(lo), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_op(MULTU, 32'd6, 32'd7, 1'b0);
    expect_result("after rst 6*7", 32'd0, 32'h0000_002A, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
